// File: rtl/latch_drive_serializer_pkg.sv
// Shared definitions for the latch drive serializer: FSM state encoding and
// default sizing constants.
package latch_drive_serializer_pkg;

    localparam int DEFAULT_WIDTH       = 8;
    localparam int DEFAULT_GATE_CYCLES = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        GATE  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/latch_drive_serializer_shift_reg.sv
// WIDTH-bit load/shift register; bit_o is the bit that becomes current after
// the coming clock edge, so the caller can register it in the same cycle.
module serializer_shift_reg
    import latch_drive_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             msb_first_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             bit_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             dir_q, dir_d;

    always_comb begin
        data_d = data_q;
        dir_d  = dir_q;
        if (load_i) begin
            data_d = din_i;
            dir_d  = msb_first_i;
        end else if (shift_i) begin
            data_d = dir_q ? {data_q[WIDTH-2:0], 1'b0} : {1'b0, data_q[WIDTH-1:1]};
        end
    end

    assign bit_o = dir_d ? data_d[WIDTH-1] : data_d[0];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= '0;
            dir_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            dir_q  <= dir_d;
        end
    end

endmodule

// File: rtl/latch_drive_serializer.sv
// Parallel-to-serial driver for a gated D latch: each bit gets one setup cycle
// with the gate low followed by GATE_CYCLES cycles with the gate high.
module latch_drive_serializer
    import latch_drive_serializer_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         start_i,
    input  logic [WIDTH-1:0]             din_i,
    input  logic                         msb_first_i,
    input  logic                         set_n_i,
    input  logic                         clr_n_i,
    output logic                         ser_d_o,
    output logic                         ser_g_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt_o
);

    localparam int                CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WIDTH - 1);
    localparam logic [3:0]        GATE_LAST = 4'(GATE_CYCLES);

    state_e             state_q, state_d;
    logic               ser_d_q, ser_d_d;
    logic               ser_g_q, ser_g_d;
    logic               busy_q, done_q;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [3:0]         gate_cnt_q, gate_cnt_d;
    logic               load, shift, gate_end, sr_bit;

    assign load     = (state_q == IDLE) && start_i;
    assign gate_end = (state_q == GATE) && (gate_cnt_q == GATE_LAST);
    assign shift    = gate_end && (bit_cnt_q != LAST_BIT);

    serializer_shift_reg #(.WIDTH(WIDTH)) u_shift (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .load_i      (load),
        .shift_i     (shift),
        .msb_first_i (msb_first_i),
        .din_i       (din_i),
        .bit_o       (sr_bit)
    );

    always_comb begin
        state_d    = state_q;
        ser_d_d    = ser_d_q;
        ser_g_d    = 1'b0;
        bit_cnt_d  = bit_cnt_q;
        gate_cnt_d = gate_cnt_q;
        case (state_q)
            IDLE: begin
                // An accepted start masks the overrides; clear beats set.
                if (load) begin
                    bit_cnt_d = '0;
                    ser_d_d   = sr_bit;
                    state_d   = SETUP;
                end else if (!clr_n_i) begin
                    ser_d_d = 1'b0;
                    ser_g_d = 1'b1;
                end else if (!set_n_i) begin
                    ser_d_d = 1'b1;
                    ser_g_d = 1'b1;
                end
            end
            SETUP: begin
                state_d    = GATE;
                ser_g_d    = 1'b1;
                gate_cnt_d = 4'd1;
            end
            GATE: begin
                if (gate_end) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (shift) begin
                        ser_d_d = sr_bit;
                        state_d = SETUP;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    ser_g_d    = 1'b1;
                    gate_cnt_d = gate_cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            ser_d_q    <= 1'b0;
            ser_g_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bit_cnt_q  <= '0;
            gate_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ser_d_q    <= ser_d_d;
            ser_g_q    <= ser_g_d;
            busy_q     <= (state_d == SETUP) || (state_d == GATE);
            done_q     <= (state_d == DONE);
            bit_cnt_q  <= bit_cnt_d;
            gate_cnt_q <= gate_cnt_d;
        end
    end

    assign ser_d_o   = ser_d_q;
    assign ser_g_o   = ser_g_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign bit_cnt_o = bit_cnt_q;

endmodule

// File: tb/tb_latch_drive_serializer.sv
// Directed bench for latch_drive_serializer: two instances (gate length 1 and 3)
// share stimulus; expected frames are derived from the word and bit order.
module tb_latch_drive_serializer;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  din = '0;
    logic          msb_first = 1'b0;
    logic          set_n = 1'b1;
    logic          clr_n = 1'b1;

    logic          ser_d1, ser_g1, busy1, done1;
    logic [CW-1:0] bit_cnt1;
    logic          ser_d3, ser_g3, busy3, done3;
    logic [CW-1:0] bit_cnt3;
    logic          prev_d1 = 1'b0;
    logic          prev_d3 = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    latch_drive_serializer #(.WIDTH(W), .GATE_CYCLES(1)) dut1 (
        .clk_i(clk), .reset_i(reset), .start_i(start), .din_i(din),
        .msb_first_i(msb_first), .set_n_i(set_n), .clr_n_i(clr_n),
        .ser_d_o(ser_d1), .ser_g_o(ser_g1), .busy_o(busy1), .done_o(done1),
        .bit_cnt_o(bit_cnt1)
    );

    latch_drive_serializer #(.WIDTH(W), .GATE_CYCLES(3)) dut3 (
        .clk_i(clk), .reset_i(reset), .start_i(start), .din_i(din),
        .msb_first_i(msb_first), .set_n_i(set_n), .clr_n_i(clr_n),
        .ser_d_o(ser_d3), .ser_g_o(ser_g3), .busy_o(busy3), .done_o(done3),
        .bit_cnt_o(bit_cnt3)
    );

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [W-1:0] d, input logic msb,
                                 input logic sn, input logic cn);
        start     = st;
        din       = d;
        msb_first = msb;
        set_n     = sn;
        clr_n     = cn;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pack1();
        return {1'b0, ser_d1, ser_g1, busy1, done1, bit_cnt1};
    endfunction

    function automatic logic [7:0] pack3();
        return {1'b0, ser_d3, ser_g3, busy3, done3, bit_cnt3};
    endfunction

    // Gate must never open or stay open around a data change while framing.
    always @(negedge clk) begin
        if (!reset && busy1 && ser_g1) checkOutput("stable_d1", {7'd0, ser_d1}, {7'd0, prev_d1});
        if (!reset && busy3 && ser_g3) checkOutput("stable_d3", {7'd0, ser_d3}, {7'd0, prev_d3});
        if (busy1 || done1) checkOutput("busy_done1", {7'd0, busy1 & done1}, 8'd0);
        if (busy3 || done3) checkOutput("busy_done3", {7'd0, busy3 & done3}, 8'd0);
        prev_d1 = ser_d1;
        prev_d3 = ser_d3;
    end

    // disturb: 0 none, 1 second start at cycle 3, 2 set/clr overrides mid-frame
    task automatic frameG1(input logic [W-1:0] w, input logic msb, input int disturb, input string name);
        logic       bitv, lastv, gv;
        logic [7:0] exp;
        int         i;
        lastv = msb ? w[0] : w[W-1];
        applyStimulus(1'b1, w, msb, 1'b1, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            i = (c - 1) / 2;
            if (c <= 8) begin
                bitv = msb ? w[W-1-i] : w[i];
                gv   = ((c - 1) % 2) == 1;
                exp  = {1'b0, bitv, gv, 1'b1, 1'b0, 3'(i)};
            end else if (c == 9) begin
                exp = {1'b0, lastv, 1'b0, 1'b0, 1'b1, 3'd4};
            end else begin
                exp = {1'b0, lastv, 1'b0, 1'b0, 1'b0, 3'd4};
            end
            checkOutput($sformatf("%s_c%0d", name, c), pack1(), exp);
            if (disturb == 1 && c == 3)
                applyStimulus(1'b1, 4'b0000, ~msb, 1'b1, 1'b1);
            else if (disturb == 2 && c >= 2 && c <= 6)
                applyStimulus(1'b0, w, msb, 1'b0, (c == 4) ? 1'b0 : 1'b1);
            else
                applyStimulus(1'b0, w, msb, 1'b1, 1'b1);
        end
    endtask

    task automatic frameG3(input logic [W-1:0] w, input logic msb, input string name);
        logic       bitv, lastv, gv;
        logic [7:0] exp;
        int         i;
        lastv = msb ? w[0] : w[W-1];
        applyStimulus(1'b1, w, msb, 1'b1, 1'b1);
        for (int c = 1; c <= 18; c++) begin
            i = (c - 1) / 4;
            if (c <= 16) begin
                bitv = msb ? w[W-1-i] : w[i];
                gv   = ((c - 1) % 4) != 0;
                exp  = {1'b0, bitv, gv, 1'b1, 1'b0, 3'(i)};
            end else if (c == 17) begin
                exp = {1'b0, lastv, 1'b0, 1'b0, 1'b1, 3'd4};
            end else begin
                exp = {1'b0, lastv, 1'b0, 1'b0, 1'b0, 3'd4};
            end
            checkOutput($sformatf("%s_c%0d", name, c), pack3(), exp);
            applyStimulus(1'b0, w, msb, 1'b1, 1'b1);
        end
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        $display("[TB] start");
        reset = 1'b1;
        idleCycles(2);
        checkOutput("reset_dut1", pack1(), 8'd0);
        checkOutput("reset_dut3", pack3(), 8'd0);
        reset = 1'b0;
        idleCycles(2);

        frameG1(4'b1011, 1'b1, 0, "msb");
        frameG1(4'b1011, 1'b0, 0, "lsb");
        frameG1(4'b1011, 1'b1, 1, "start_busy");
        frameG1(4'b0110, 1'b0, 2, "ovr_busy");

        idleCycles(20);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("ovr_set", pack1(), {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4});
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("ovr_both", pack1(), {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4});
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("ovr_set2", pack1(), {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4});
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        checkOutput("ovr_release", pack1(), {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4});
        applyStimulus(1'b1, 4'b1011, 1'b1, 1'b0, 1'b0);
        checkOutput("start_over_ovr", pack1(), {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0});

        idleCycles(20);
        frameG3(4'b1011, 1'b0, "g3");

        idleCycles(20);
        applyStimulus(1'b1, 4'b1011, 1'b1, 1'b1, 1'b1);
        idleCycles(3);
        reset = 1'b1;
        idleCycles(1);
        checkOutput("midreset_dut1", pack1(), 8'd0);
        checkOutput("midreset_dut3", pack3(), 8'd0);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            checkOutput($sformatf("no_done_%0d", k), {4'd0, busy1, done1, busy3, done3}, 8'd0);
            idleCycles(1);
        end
        frameG1(4'b0110, 1'b1, 0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
